// File: rtl/fetch_pkg.sv
// Shared widths, constants and the prefetch queue entry type for the fetch unit.
// Latency: none (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    // Returned for fetches beyond the end of the instruction memory.
    localparam logic [DATA_W-1:0] NOP_WORD = 16'h0000;

    // Default first fetch address after reset.
    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;

    // One queued instruction as delivered to decode.
    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic              oor;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read combinationally.
// Latency: a pushed entry becomes visible at the head on the following cycle.
// Backpressure: none internally; the producer must hold pushes off when full.
//
// Ports: clk, flush_i (clears contents, has priority), push_i/push_dat_i,
//        pop_i, head_o (current head entry), count_o (occupancy 0..DEPTH).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_dat_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       store_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_i && !pop_i)      cnt_d = cnt_q + CNT_W'(1);
            else if (!push_i && pop_i) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        if (push_i && !flush_i) store_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_o  = store_q[rd_ptr_q];
    assign count_o = cnt_q;

    // The credit scheme upstream must never let a push land on a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (flush_i)
        !(push_i && (cnt_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/instr_fetch_unit.sv
// Writable instruction memory with a credit-limited prefetch queue feeding decode.
// Latency: first instruction valid two cycles after reset release or redirect; then 1/cycle.
// Backpressure: out_ready low holds the head stable; prefetch stops once queued+in-flight fill the queue.
//
// Ports: clk/rst (sync, active high); prog_we/prog_addr/prog_data load the memory;
//        redirect_valid/redirect_pc restart fetch; out_valid/out_ready handshake
//        with out_instr/out_pc/out_oor describing the head instruction.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DEPTH      = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_oor
);

    localparam int MEM_AW = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    fetch_entry_t      rd_q;

    logic              restart;
    logic [ADDR_W-1:0] fetch_word;
    logic              fetch_oor;
    logic [ADDR_W-1:0] prog_word;
    logic              prog_oor;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occupancy;
    logic              issue;
    logic              fifo_empty;
    logic              pop;
    logic              fifo_push;
    logic              fifo_pop;
    fetch_entry_t      fifo_head;
    fetch_entry_t      head;

    // Reset and redirect both discard queued and in-flight words.
    assign restart = rst | redirect_valid;

    assign fetch_word = fetch_pc_q >> 1;
    assign fetch_oor  = (fetch_word >= ADDR_W'(DEPTH));
    assign prog_word  = prog_addr >> 1;
    assign prog_oor   = (prog_word >= ADDR_W'(DEPTH));

    // Credits count the registered occupancy only, so a pop this cycle does
    // not free a slot until the next one.
    assign occupancy = fifo_count + CNT_W'(inflight_q);
    assign issue     = !restart && (occupancy < CNT_W'(FIFO_DEPTH));

    // The read register acts as a bypass stage: while the queue is empty the
    // word just read is offered to decode directly, which is what gives the
    // two-cycle restart latency and one-per-cycle streaming.
    assign fifo_empty = (fifo_count == '0);
    assign head       = fifo_empty ? rd_q : fifo_head;
    assign out_valid  = !fifo_empty || inflight_q;
    assign pop        = out_valid && out_ready;
    // A word consumed straight from the read register never enters the queue.
    assign fifo_push  = inflight_q && !(fifo_empty && pop) && !restart;
    assign fifo_pop   = pop && !fifo_empty && !restart;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .flush_i    (restart),
        .push_i     (fifo_push),
        .push_dat_i (rd_q),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = issue;
        if (rst) begin
            fetch_pc_d = RESET_PC;
            inflight_d = 1'b0;
        end else if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~ADDR_W'(1);
            inflight_d = 1'b0;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(2);
        end
    end

    always_ff @(posedge clk) begin
        fetch_pc_q <= fetch_pc_d;
        inflight_q <= inflight_d;
    end

    // Synchronous read; data is only meaningful while inflight_q is set.
    always_ff @(posedge clk) begin
        if (issue) begin
            rd_q.instr <= fetch_oor ? NOP_WORD : mem_q[fetch_word[MEM_AW-1:0]];
            rd_q.pc    <= fetch_pc_q;
            rd_q.oor   <= fetch_oor;
        end
    end

    // Nonblocking write alongside the read above gives read-before-write on
    // a same-index collision. Memory is deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (prog_we && !prog_oor) mem_q[prog_word[MEM_AW-1:0]] <= prog_data;
    end

    assign out_instr = out_valid ? head.instr : NOP_WORD;
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_oor   = out_valid ? head.oor   : 1'b0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [15:0] NOP    = 16'h0000;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [15:0] prog_addr;
    logic [15:0] prog_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        out_oor;

    instr_fetch_unit #(
        .DEPTH      (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_oor        (out_oor)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          model_en = 1'b0;
    logic [15:0] mem_m [32];
    logic [15:0] exp_pc;
    int          age;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        chk;
        logic        v;
        logic [15:0] instr;
        logic [15:0] pc;
        logic        oor;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic rdy, input logic redir, input logic [15:0] rpc,
                                input logic chk, input logic v, input logic [15:0] instr,
                                input logic [15:0] pc, input logic oor);
        vec_t t;
        t.rdy = rdy; t.redir = redir; t.rpc = rpc; t.chk = chk;
        t.v = v; t.instr = instr; t.pc = pc; t.oor = oor;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input logic [15:0] pc);
        if ((pc >> 1) < 16'd32) return mem_m[pc[5:1]];
        return NOP;
    endfunction

    // Checks outputs for the current cycle against the model, advances the
    // model across the coming edge using the inputs already applied, ticks.
    // Model: after a restart the stream is valid from the second cycle on and
    // carries consecutive halfword addresses, advancing only on accepted pops.
    task automatic cycle();
        logic ev;
        if (model_en) begin
            ev = (age >= 2);
            chk("m_valid", out_valid, ev);
            if (ev) begin
                chk("m_pc", out_pc, exp_pc);
                chk("m_instr", out_instr, model_word(exp_pc));
                chk("m_oor", out_oor, ((exp_pc >> 1) >= 16'd32));
            end else begin
                chk("m_idle_instr", out_instr, NOP);
                chk("m_idle_pc", out_pc, 16'h0000);
                chk("m_idle_oor", out_oor, 1'b0);
            end
        end
        if (rst) begin
            exp_pc = RST_PC;
            age    = 1;
        end else if (redirect_valid) begin
            exp_pc = redirect_pc & 16'hFFFE;
            age    = 1;
        end else begin
            if (age >= 2 && out_ready) exp_pc = exp_pc + 16'd2;
            if (age < 1000) age++;
        end
        if (prog_we && ((prog_addr >> 1) < 16'd32)) mem_m[prog_addr[5:1]] = prog_data;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [15:0] data);
        prog_we   = 1'b1;
        prog_addr = 16'(idx * 2);
        prog_data = data;
        cycle();
        prog_we   = 1'b0;
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] old5;

        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        exp_pc = RST_PC; age = 0;
        @(posedge clk);
        #1;
        cycle();
        model_en = 1'b1;

        // Load the whole memory while reset is held; every cycle checks idle outputs.
        for (int i = 0; i < 32; i++) load(i, 16'hF010 + 16'(i * 16));
        rst = 1'b0;

        // Directed table: stream, boundary at the last word, out-of-range, wrap.
        tbl[0]  = mk(1, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        tbl[1]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0);
        tbl[2]  = mk(1, 0, 16'h0000, 1, 1, 16'hF010, 16'h0000, 0);
        tbl[3]  = mk(1, 0, 16'h0000, 1, 1, 16'hF020, 16'h0002, 0);
        tbl[4]  = mk(1, 0, 16'h0000, 1, 1, 16'hF030, 16'h0004, 0);
        tbl[5]  = mk(1, 0, 16'h0000, 1, 1, 16'hF040, 16'h0006, 0);
        tbl[6]  = mk(1, 0, 16'h0000, 1, 1, 16'hF050, 16'h0008, 0);
        tbl[7]  = mk(1, 1, 16'h003E, 1, 1, 16'hF060, 16'h000A, 0);
        tbl[8]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0);
        tbl[9]  = mk(1, 0, 16'h0000, 1, 1, 16'hF200, 16'h003E, 0);
        tbl[10] = mk(1, 0, 16'h0000, 1, 1, NOP,      16'h0040, 1);
        tbl[11] = mk(1, 1, 16'hFFFE, 1, 1, NOP,      16'h0042, 1);
        tbl[12] = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0);
        tbl[13] = mk(1, 0, 16'h0000, 1, 1, NOP,      16'hFFFE, 1);
        tbl[14] = mk(1, 0, 16'h0000, 1, 1, 16'hF010, 16'h0000, 0);
        tbl[15] = mk(1, 0, 16'h0000, 1, 1, 16'hF020, 16'h0002, 0);
        for (int r = 0; r < 16; r++) begin
            out_ready      = tbl[r].rdy;
            redirect_valid = tbl[r].redir;
            redirect_pc    = tbl[r].rpc;
            if (tbl[r].chk) begin
                chk($sformatf("tbl%0d_valid", r), out_valid, tbl[r].v);
                chk($sformatf("tbl%0d_instr", r), out_instr, tbl[r].instr);
                chk($sformatf("tbl%0d_pc", r),    out_pc,    tbl[r].pc);
                chk($sformatf("tbl%0d_oor", r),   out_oor,   tbl[r].oor);
            end
            cycle();
        end
        redirect_valid = 1'b0;

        // Stall after reset: head holds at RESET_PC, then drains without gaps.
        rst = 1'b1; out_ready = 1'b0; cycle(); rst = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        // Redirect to an odd address while three entries are queued, pop ignored.
        rst = 1'b1; out_ready = 1'b0; cycle(); rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        out_ready = 1'b1;
        redirect_to(16'h001B);
        cycle();
        chk("redir_odd_valid", out_valid, 1'b1);
        chk("redir_odd_pc", out_pc, 16'h001A);
        for (int i = 0; i < 3; i++) cycle();

        // Write to index 5 in the same cycle its fetch is issued: old data first.
        model_en = 1'b0;
        old5 = mem_m[5];
        redirect_to(16'h000A);
        prog_we = 1'b1; prog_addr = 16'h000A; prog_data = 16'hBEEF;
        chk("rbw_issue_cycle_valid", out_valid, 1'b0);
        cycle();
        prog_we = 1'b0;
        chk("rbw_old_valid", out_valid, 1'b1);
        chk("rbw_old_instr", out_instr, old5);
        chk("rbw_old_pc", out_pc, 16'h000A);
        cycle();
        redirect_to(16'h000A);
        cycle();
        chk("rbw_new_instr", out_instr, 16'hBEEF);
        chk("rbw_new_pc", out_pc, 16'h000A);
        model_en = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Reset with the queue nearly full and a read in flight; memory survives.
        out_ready = 1'b0;
        redirect_to(16'h0010);
        for (int i = 0; i < 4; i++) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("rst_mid_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();

        // Randomised traffic: random ready, sparse redirects and resets.
        for (int i = 0; i < 3000; i++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                         : 16'($urandom_range(0, 16'h0050));
            rst            = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
